// File: rtl/updown_counter.sv
// Up/down counter over the runtime range 0..max_i with load, wrap or saturate
// terminal behaviour, and registered last/wrap pulses.
module updown_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ena_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic [WIDTH-1:0] max_i,
  output logic [WIDTH-1:0] count_o,
  output logic             last_o,
  output logic             wrap_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q = '0;
  logic             last_q  = 1'b0;
  logic             wrap_q  = 1'b0;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] dec;

  // Only used when count < max_i (inc) or count > 0 (dec), so never overflows.
  assign inc = count_q + WIDTH'(1);
  assign dec = count_q - WIDTH'(1);

  always_ff @(posedge clk_i) begin
    last_q <= 1'b0;
    wrap_q <= 1'b0;
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (ena_i) begin
      if (up_i) begin
        if (count_q < max_i) begin
          count_q <= inc;
          last_q  <= (inc == max_i);
        end else if (SATURATE) begin
          // holds at max_i, or clamps an out-of-range count down to it
          count_q <= max_i;
        end else begin
          count_q <= '0;
          wrap_q  <= 1'b1;
        end
      end else begin
        if (count_q > max_i) begin
          count_q <= max_i;
        end else if (count_q == '0) begin
          if (!SATURATE) begin
            count_q <= max_i;
            wrap_q  <= 1'b1;
          end
        end else begin
          count_q <= dec;
          last_q  <= (dec == '0);
        end
      end
    end
  end

  assign count_o = count_q;
  assign last_o  = last_q;
  assign wrap_o  = wrap_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: three instances (4-bit wrap, 8-bit wrap, 8-bit
// saturate) on shared inputs, directed scenarios plus random vs a modular model.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0, ena = 1'b0, up = 1'b0, ld = 1'b0;
  logic [7:0] val = '0, mx = '0;

  logic [3:0] c4;
  logic [7:0] c0, c1;
  logic       l4, w4, z4, l0, w0, z0, l1, w1, z1;

  int total = 0;
  int bad   = 0;
  int mc[3], ml[3], mw[3];

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4), .SATURATE(1'b0)) u_w4 (
    .clk_i(clk), .rst_i(rst), .ena_i(ena), .up_i(up), .load_i(ld),
    .value_i(val[3:0]), .max_i(mx[3:0]),
    .count_o(c4), .last_o(l4), .wrap_o(w4), .zero_o(z4));

  updown_counter #(.WIDTH(8), .SATURATE(1'b0)) u_s0 (
    .clk_i(clk), .rst_i(rst), .ena_i(ena), .up_i(up), .load_i(ld),
    .value_i(val), .max_i(mx),
    .count_o(c0), .last_o(l0), .wrap_o(w0), .zero_o(z0));

  updown_counter #(.WIDTH(8), .SATURATE(1'b1)) u_s1 (
    .clk_i(clk), .rst_i(rst), .ena_i(ena), .up_i(up), .load_i(ld),
    .value_i(val), .max_i(mx),
    .count_o(c1), .last_o(l1), .wrap_o(w1), .zero_o(z1));

  function automatic int wid(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic bit sat(input int i);
    return (i == 2);
  endfunction

  // Reference: range 0..m treated as a ring of m+1 values (wrap) or a clamped
  // interval (saturate); last = an in-range move that lands on the terminal.
  task automatic model_step(input int i);
    int msk, m, v, c, nx, wr;
    msk = (1 << wid(i)) - 1;
    m   = int'(mx) & msk;
    v   = int'(val) & msk;
    c   = mc[i];
    nx  = c;
    wr  = 0;
    if (rst != 0)      nx = 0;
    else if (ld != 0)  nx = v;
    else if (ena != 0) begin
      if (c > m) begin
        nx = (up != 0 && !sat(i)) ? 0 : m;
        wr = (up != 0 && !sat(i)) ? 1 : 0;
      end else if (sat(i)) begin
        nx = (up != 0) ? ((c + 1 < m) ? c + 1 : m) : ((c > 0) ? c - 1 : 0);
      end else begin
        nx = (up != 0) ? (c + 1) % (m + 1) : (c + m) % (m + 1);
        wr = (up != 0) ? ((c == m) ? 1 : 0) : ((c == 0) ? 1 : 0);
      end
    end
    ml[i] = (rst == 0 && ld == 0 && ena != 0 && c <= m && wr == 0 && nx != c &&
             nx == ((up != 0) ? m : 0)) ? 1 : 0;
    mw[i] = wr;
    mc[i] = nx;
  endtask

  task automatic cyc(input int r, input int l, input int v, input int e,
                     input int u, input int m);
    rst = (r != 0); ld = (l != 0); val = 8'(v);
    ena = (e != 0); up = (u != 0); mx = 8'(m);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) model_step(i);
  endtask

  task automatic get_obs(input int i, output logic [31:0] c, output logic l,
                         output logic w, output logic z);
    case (i)
      0:       begin c = {28'd0, c4}; l = l4; w = w4; z = z4; end
      1:       begin c = {24'd0, c0}; l = l0; w = w0; z = z0; end
      default: begin c = {24'd0, c1}; l = l1; w = w1; z = z1; end
    endcase
  endtask

  task automatic test_reset;
    #1;
    total++;
    if (c0 !== 8'd0 || l0 !== 1'b0 || w0 !== 1'b0 || z0 !== 1'b1) begin
      bad++;
      $display("FAIL powerup got c=%0d l=%b w=%b z=%b want 0 0 0 1", c0, l0, w0, z0);
    end
    cyc(0, 1, 7, 0, 0, 9);
    cyc(1, 0, 0, 0, 0, 9);
    total++;
    if (c0 !== 8'd0 || c1 !== 8'd0 || c4 !== 4'd0 || l0 !== 1'b0 || w0 !== 1'b0 || z0 !== 1'b1) begin
      bad++;
      $display("FAIL reset got c0=%0d c1=%0d c4=%0d l=%b w=%b z=%b want 0", c0, c1, c4, l0, w0, z0);
    end
  endtask

  task automatic test_wrap_up;
    int ec;
    cyc(1, 0, 0, 0, 0, 9);
    for (int k = 0; k < 12; k++) begin
      cyc(0, 0, 0, 1, 1, 9);
      ec = (k + 1) % 10;
      total++;
      if (c4 !== 4'(ec) || l4 !== (ec == 9) || w4 !== (k == 9)) begin
        bad++;
        $display("FAIL wrap_up k=%0d got c=%0d l=%b w=%b want c=%0d l=%b w=%b",
                 k, c4, l4, w4, ec, ec == 9, k == 9);
      end
    end
  endtask

  task automatic test_wrap_down;
    int ec;
    cyc(0, 1, 0, 0, 0, 5);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 1, 0, 5);
      ec = 5 - k;
      total++;
      if (c0 !== 8'(ec) || l0 !== 1'b0 || w0 !== (k == 0)) begin
        bad++;
        $display("FAIL wrap_down k=%0d got c=%0d l=%b w=%b want c=%0d l=0 w=%b",
                 k, c0, l0, w0, ec, k == 0);
      end
    end
  endtask

  task automatic test_saturate;
    int ec;
    cyc(1, 0, 0, 0, 0, 3);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 0, 1, 1, 3);
      ec = (k < 2) ? k + 1 : 3;
      total++;
      if (c1 !== 8'(ec) || l1 !== (k == 2) || w1 !== 1'b0) begin
        bad++;
        $display("FAIL saturate k=%0d got c=%0d l=%b w=%b want c=%0d l=%b w=0",
                 k, c1, l1, w1, ec, k == 2);
      end
    end
  endtask

  task automatic test_max_change;
    cyc(0, 1, 12, 0, 0, 15);
    cyc(0, 0, 0, 1, 1, 7);
    total++;
    if (c0 !== 8'd0 || w0 !== 1'b1 || l0 !== 1'b0 || c1 !== 8'd7 || w1 !== 1'b0 || l1 !== 1'b0) begin
      bad++;
      $display("FAIL oor_up got s0 c=%0d w=%b l=%b s1 c=%0d w=%b l=%b want 0 1 0 / 7 0 0",
               c0, w0, l0, c1, w1, l1);
    end
    cyc(0, 1, 12, 0, 0, 7);
    cyc(0, 0, 0, 1, 0, 7);
    total++;
    if (c0 !== 8'd7 || w0 !== 1'b0 || l0 !== 1'b0 || c1 !== 8'd7 || w1 !== 1'b0 || l1 !== 1'b0) begin
      bad++;
      $display("FAIL oor_down got s0 c=%0d w=%b l=%b s1 c=%0d w=%b l=%b want 7 0 0 / 7 0 0",
               c0, w0, l0, c1, w1, l1);
    end
  endtask

  task automatic test_priority;
    cyc(0, 1, 3, 0, 0, 9);
    cyc(1, 1, 6, 1, 1, 9);
    total++;
    if (c0 !== 8'd0 || l0 !== 1'b0 || w0 !== 1'b0) begin
      bad++;
      $display("FAIL prio_rst got c=%0d l=%b w=%b want 0 0 0", c0, l0, w0);
    end
    cyc(0, 1, 6, 1, 1, 9);
    total++;
    if (c0 !== 8'd6 || l0 !== 1'b0 || w0 !== 1'b0) begin
      bad++;
      $display("FAIL prio_load got c=%0d l=%b w=%b want 6 0 0", c0, l0, w0);
    end
  endtask

  task automatic test_full_range;
    cyc(0, 1, 255, 0, 0, 255);
    cyc(0, 0, 0, 1, 1, 255);
    total++;
    if (c0 !== 8'd0 || w0 !== 1'b1 || l0 !== 1'b0 || z0 !== 1'b1) begin
      bad++;
      $display("FAIL full_range got c=%0d w=%b l=%b z=%b want 0 1 0 1", c0, w0, l0, z0);
    end
  endtask

  task automatic test_hold_and_midreset;
    cyc(0, 1, 4, 0, 0, 5);
    cyc(0, 0, 0, 1, 1, 5);
    cyc(0, 0, 0, 0, 0, 5);
    total++;
    if (c0 !== 8'd5 || l0 !== 1'b0 || w0 !== 1'b0) begin
      bad++;
      $display("FAIL hold got c=%0d l=%b w=%b want 5 0 0", c0, l0, w0);
    end
    cyc(0, 1, 8, 0, 0, 9);
    cyc(0, 0, 0, 1, 1, 9);
    cyc(1, 0, 0, 1, 1, 9);
    total++;
    if (c0 !== 8'd0 || l0 !== 1'b0 || w0 !== 1'b0) begin
      bad++;
      $display("FAIL midreset got c=%0d l=%b w=%b want 0 0 0", c0, l0, w0);
    end
    cyc(0, 0, 0, 1, 1, 9);
    total++;
    if (c0 !== 8'd1 || l0 !== 1'b0 || w0 !== 1'b0) begin
      bad++;
      $display("FAIL after_reset got c=%0d l=%b w=%b want 1 0 0", c0, l0, w0);
    end
  endtask

  task automatic test_max_zero;
    cyc(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 1, k % 2, 0);
      total++;
      if (c0 !== 8'd0 || w0 !== 1'b1 || l0 !== 1'b0 || c1 !== 8'd0 || w1 !== 1'b0 || l1 !== 1'b0) begin
        bad++;
        $display("FAIL max_zero k=%0d got s0 c=%0d w=%b l=%b s1 c=%0d w=%b l=%b",
                 k, c0, w0, l0, c1, w1, l1);
      end
    end
  endtask

  task automatic test_random;
    int m;
    logic [31:0] oc;
    logic ol, ow, oz;
    m = 9;
    cyc(1, 0, 0, 0, 0, m);
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0:       m = 0;
          1:       m = 255;
          2:       m = int'($urandom_range(0, 255));
          default: m = int'($urandom_range(1, 15));
        endcase
      end
      cyc(($urandom_range(0, 49) == 0) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0,
          int'($urandom_range(0, 255)), ($urandom_range(0, 5) != 0) ? 1 : 0,
          int'($urandom_range(0, 1)), m);
      for (int i = 0; i < 3; i++) begin
        get_obs(i, oc, ol, ow, oz);
        total++;
        if (oc !== 32'(mc[i]) || ol !== (ml[i] != 0) || ow !== (mw[i] != 0) ||
            oz !== (mc[i] == 0) || (ol === 1'b1 && ow === 1'b1)) begin
          bad++;
          $display("FAIL random k=%0d inst=%0d got c=%0d l=%b w=%b z=%b want c=%0d l=%0d w=%0d",
                   k, i, oc, ol, ow, oz, mc[i], ml[i], mw[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin mc[i] = 0; ml[i] = 0; mw[i] = 0; end
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_max_change();
    test_priority();
    test_full_range();
    test_hold_and_midreset();
    test_max_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
